regfile_2r1w: RTL and testbench



---
 rtl/regfile_2r1w.sv | 84 ++++++++
 tb/tb_regfile_2r1w.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with r0 hard-wired to zero.
// Combinational reads, rising-edge writes, flat debug export.

module regfile_dec #(
  parameter int W = 5
) (
  input  logic           ena,
  input  logic [W-1:0]   addr,
  output logic [2**W-1:0] decoded
);

  always_comb begin
    decoded = '0;
    if (ena) decoded[addr] = 1'b1;
  end

endmodule

module regfile_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (ena)
      q <= d;
  end

endmodule

module regfile_2r1w #(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    rd_addr0,
  input  logic [4:0]    rd_addr1,
  input  logic [4:0]    wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic          wr_ena,
  output logic [N-1:0]  rd_data0,
  output logic [N-1:0]  rd_data1,
  output logic [32*N-1:0] full_register_file
);

  logic [31:0]  dec;
  logic [N-1:0] mem [32];
  logic         unused_dec0;

  regfile_dec #(.W(5)) u_dec (
    .ena     (wr_ena),
    .addr    (wr_addr),
    .decoded (dec)
  );

  // r0 has no storage, so its decode line is dropped
  assign unused_dec0 = dec[0];
  assign mem[0] = '0;

  for (genvar k = 1; k < 32; k++) begin : g_reg
    regfile_reg #(.N(N)) u_reg (
      .clk (clk),
      .rst (rst),
      .ena (dec[k]),
      .d   (wr_data),
      .q   (mem[k])
    );
  end

  for (genvar k = 0; k < 32; k++) begin : g_flat
    assign full_register_file[k*N +: N] = mem[k];
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: model array, expected
// values queued on stimulus and popped when outputs settle.

module tb_regfile_2r1w;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rd_addr0, rd_addr1, wr_addr;
  logic [31:0]   wr_data;
  logic          wr_ena;
  logic [31:0]   rd_data0, rd_data1;
  logic [1023:0] full_register_file;

  logic [31:0] model [32];
  logic [31:0] sb [$];
  int n_chk = 0;
  int n_err = 0;

  regfile_2r1w #(.N(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .rd_addr0           (rd_addr0),
    .rd_addr1           (rd_addr1),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .wr_ena             (wr_ena),
    .rd_data0           (rd_data0),
    .rd_data1           (rd_data1),
    .full_register_file (full_register_file)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 32; k++) model[k] = '0;
  endtask

  task automatic read_chk(input logic [4:0] a0,
                          input logic [4:0] a1);
    rd_addr0 = a0;
    rd_addr1 = a1;
    sb.push_back(model[a0]);
    sb.push_back(model[a1]);
    #1;
    check($sformatf("rd0[%0d]", a0), rd_data0, sb.pop_front());
    check($sformatf("rd1[%0d]", a1), rd_data1, sb.pop_front());
  endtask

  task automatic full_chk(input string tag);
    logic [31:0] e;
    for (int k = 0; k < 32; k++) sb.push_back(model[k]);
    #1;
    for (int k = 0; k < 32; k++) begin
      e = sb.pop_front();
      check($sformatf("%s_full[%0d]", tag, k),
            full_register_file[k*32 +: 32], e);
    end
  endtask

  // Drive away from the edge, capture on the next posedge
  task automatic write(input logic [4:0] a,
                       input logic [31:0] d);
    wr_addr = a;
    wr_data = d;
    wr_ena  = 1'b1;
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  initial begin
    rst      = 1'b0;
    rd_addr0 = '0;
    rd_addr1 = '0;
    wr_addr  = 5'd5;
    wr_data  = 32'hDEADBEEF;
    wr_ena   = 1'b1;
    model_clear();

    repeat (3) @(posedge clk);
    #2;
    read_chk(5, 5);
    read_chk(0, 31);
    full_chk("rst");
    wr_ena = 1'b0;
    rst = 1'b1;
    #2;

    write(1, 32'h12345678);
    write(31, 32'hFFFFFFFF);
    read_chk(1, 31);
    check("full_r0", full_register_file[31:0], 32'h0);
    check("full_r31", full_register_file[1023:992], 32'hFFFFFFFF);

    write(0, 32'hAAAA5555);
    read_chk(0, 0);
    full_chk("zero");

    wr_addr = 5'd7;
    wr_data = 32'h1;
    wr_ena  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    read_chk(7, 7);

    write(3, 32'h11);
    wr_addr  = 5'd3;
    wr_data  = 32'h22;
    wr_ena   = 1'b1;
    read_chk(3, 3);
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    model[3] = 32'h22;
    read_chk(3, 3);

    for (int k = 1; k < 32; k++) write(k[4:0], k * 32'h01010101);
    read_chk(17, 30);
    full_chk("fill");
    #1;
    rst = 1'b0;
    model_clear();
    read_chk(17, 30);
    full_chk("arst");
    #1;
    rst = 1'b1;
    write(9, 32'hCAFEF00D);
    read_chk(9, 8);

    for (int i = 0; i < 40; i++) begin
      write(5'($urandom_range(0, 31)), $urandom);
      read_chk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    full_chk("rand");

    if (sb.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
